tpu_tile_sequencer: RTL and testbench
=====================================

Name: tpu_tile_sequencer

Overview:
Single-tile matmul sequencer for the 16x16 systolic TPU datapath. On start it pops one weight tile from the weight FIFO, pulses the systolic array's weight-reload, streams activation rows out of the unified buffer, and writes the skew-corrected results into the result SRAM. Replaces the free-running result counter and start/end state counter with one handshaked controller driven by configurable base addresses and row count.

Parameters:
ADDRESSSIZE, 10, UB and result SRAM address width
MATRIX_SIZE, 16, array dimension; informational, sizes nothing internally
PIPE_LATENCY, 33, cycles from ub_rd_en to the matching result word at the result SRAM input (>=1)
WL_SETTLE, 1, idle cycles after the we_rl pulse before the first row issue (>=0)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; accepted only in IDLE
reuse_weights  input  1  sampled with start; 1 = skip FIFO pop and reload
cfg_src_base  input  ADDRESSSIZE  first UB row address, sampled with start
cfg_dst_base  input  ADDRESSSIZE  first result SRAM address, sampled with start
cfg_num_rows  input  ADDRESSSIZE  rows to process, sampled with start
fifo_empty  input  1  weight FIFO has no tile
fifo_read_enable  output  1  weight FIFO pop
we_rl  output  1  systolic array weight reload strobe
ub_rd_en  output  1  UB read issued this cycle
ub_address  output  ADDRESSSIZE  UB read address
res_write_enable  output  1  result SRAM write
res_address  output  ADDRESSSIZE  result SRAM address
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle completion pulse

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). While rst is high all outputs are 0, FSM is IDLE, the delay line and all counters clear. Reset mid-operation abandons the tile; no further pops or writes.
- Config latched on the accepting start edge. start outside IDLE is ignored.
- States: IDLE -> WLOAD -> WRELOAD -> SETTLE -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: on start, cfg_num_rows==0 -> DONE directly (no pop, no reload, no reads); reuse_weights=1 -> SETTLE with a zero count; otherwise -> WLOAD.
- WLOAD: fifo_read_enable = !fifo_empty, registered. Waits indefinitely while fifo_empty. The cycle the pop is issued -> WRELOAD.
- WRELOAD: we_rl=1 for exactly one cycle -> SETTLE.
- SETTLE: remains WL_SETTLE cycles (0 = pass-through in one cycle) -> STREAM.
- STREAM: ub_rd_en=1 for exactly cfg_num_rows consecutive cycles with ub_address = src_base+k, k=0..N-1, sum taken mod 2^ADDRESSSIZE (wrap, no error). After the last issue -> DRAIN.
- Writeback: res_write_enable is ub_rd_en delayed by exactly PIPE_LATENCY cycles. res_address = dst_base+j mod 2^ADDRESSSIZE, where j counts writes from 0. Writes may overlap STREAM.
- DRAIN: exits when write count == cfg_num_rows -> DONE.
- DONE: done=1 for one cycle, busy=0 in that cycle -> IDLE. A start in the same cycle as done is ignored. A start in the following IDLE cycle is accepted.
- busy = (state != IDLE && state != DONE).
- Max rows = 2^ADDRESSSIZE-1. Internal counters are ADDRESSSIZE+1 bits, so terminal compares never alias.

Optional Feature:
TPU_SEQ_PERF_CNT_EN: when defined, adds output perf_cycles[31:0]. The counter clears on accepted start and increments each cycle busy=1. It saturates at all-ones and holds its value after done until the next start. Additionally adds perf_stall[15:0], cycles spent in WLOAD with fifo_empty=1, which saturates. When undefined, neither port nor any counter logic exists.

Decomposition:
- Package tpu_ctrl_pkg: state enum (IDLE, WLOAD, WRELOAD, SETTLE, STREAM, DRAIN, DONE) and default PIPE_LATENCY constant = 2*MATRIX_SIZE+1.
- Sub-module tpu_valid_delay: parameterized 1-bit shift register of depth PIPE_LATENCY with synchronous clear, producing res_write_enable.

Test Plan:
- rst high during STREAM of a 16-row tile -> next cycle all outputs 0. No res_write_enable for 40 cycles after rst is released.
- cfg_num_rows=4, src=0x010, dst=0x200, fifo_empty=0, start at t0 -> fifo_read_enable t1, we_rl t2, ub_rd_en t4..t7 at 0x010..0x013. Writes at t4+33..t7+33 to 0x200..0x203. done one cycle after the last write.
- fifo_empty=1 for 10 cycles after start -> no pop and no we_rl. Pop occurs the cycle after fifo_empty falls; perf_stall=10 when enabled.
- reuse_weights=1, num_rows=2, src=0x3FF -> no fifo_read_enable or we_rl; addresses 0x3FF then 0x000 (wrap).
- cfg_num_rows=0 -> done pulses at t1; no ub_rd_en, res_write_enable or fifo_read_enable; busy stays 0.
- start pulsed every cycle during a 3-row job -> only the first start is accepted; exactly 3 writes and one done pulse.

Source files
------------

// File: rtl/tpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_ctrl_pkg
// Purpose  : Shared types and constants for the TPU tile sequencer.
//            - seq_state_t : sequencer FSM state encoding
//            - c_MATRIX_SIZE / c_PIPE_LATENCY : array size and the default
//              ub_rd_en -> result-write latency (2*N+1 for an NxN array)
// Revision : 1.0 - initial release
// ============================================================================
package tpu_ctrl_pkg;

    localparam int c_MATRIX_SIZE  = 16;
    localparam int c_PIPE_LATENCY = 2 * c_MATRIX_SIZE + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WLOAD   = 3'd1,
        WRELOAD = 3'd2,
        SETTLE  = 3'd3,
        STREAM  = 3'd4,
        DRAIN   = 3'd5,
        DONE    = 3'd6
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/tpu_valid_delay.sv
`default_nettype none
// ============================================================================
// Module   : tpu_valid_delay
// Purpose  : 1-bit shift register of depth DEPTH with synchronous clear.
//            Delays the UB read strobe so it lines up with the result word
//            arriving at the result SRAM input.
// Ports    : clk  - clock
//            rst  - synchronous active-high clear of every stage
//            din  - strobe in
//            dout - strobe delayed by exactly DEPTH cycles
// Revision : 1.0 - initial release
// ============================================================================
module tpu_valid_delay #(
    parameter int DEPTH = 33
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 1) begin : g_single
            logic r_q;
            always_ff @(posedge clk) begin
                if (rst) r_q <= 1'b0;
                else     r_q <= din;
            end
            assign dout = r_q;
        end else begin : g_chain
            logic [DEPTH-1:0] r_q;
            always_ff @(posedge clk) begin
                if (rst) r_q <= '0;
                else     r_q <= {r_q[DEPTH-2:0], din};
            end
            assign dout = r_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tpu_tile_sequencer
// Purpose  : Single-tile matmul controller for the systolic TPU datapath.
//            On an accepted start it pops a weight tile (unless weights are
//            reused), pulses the array weight reload, streams cfg_num_rows
//            UB rows and writes the delayed results to the result SRAM.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            start, reuse_weights     - job request and weight-reuse flag
//            cfg_src_base/dst_base    - UB / result SRAM base addresses
//            cfg_num_rows             - rows in this tile (0 = no-op job)
//            fifo_empty / fifo_read_enable - weight FIFO handshake
//            we_rl                    - systolic weight reload strobe
//            ub_rd_en / ub_address    - UB row read
//            res_write_enable / res_address - result SRAM write
//            busy, done               - job status / completion pulse
// Option   : TPU_SEQ_PERF_CNT_EN adds perf_cycles[31:0] (busy cycles) and
//            perf_stall[15:0] (WLOAD cycles with empty FIFO), both saturating.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_tile_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int ADDRESSSIZE  = 10,
    parameter int MATRIX_SIZE  = c_MATRIX_SIZE,
    parameter int PIPE_LATENCY = c_PIPE_LATENCY,
    parameter int WL_SETTLE    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   reuse_weights,
    input  logic [ADDRESSSIZE-1:0] cfg_src_base,
    input  logic [ADDRESSSIZE-1:0] cfg_dst_base,
    input  logic [ADDRESSSIZE-1:0] cfg_num_rows,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_address,
    output logic                   busy,
    output logic                   done
`ifdef TPU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [15:0]            perf_stall
`endif
);

    // Counters carry one extra bit so a full 2^ADDRESSSIZE-1 row job never
    // aliases against the terminal compare.
    localparam int c_CW = ADDRESSSIZE + 1;
    // SETTLE always occupies at least one cycle, even with WL_SETTLE = 0.
    localparam int c_SETTLE_CYCLES = (WL_SETTLE < 1) ? 1 : WL_SETTLE;
    localparam int c_SW = $clog2(c_SETTLE_CYCLES + 1);

    generate
        if (PIPE_LATENCY < 1 || MATRIX_SIZE < 1) begin : g_bad_params
            $error("tpu_tile_sequencer: PIPE_LATENCY and MATRIX_SIZE must be >= 1");
        end
    endgenerate

    seq_state_t             r_state;
    seq_state_t             w_next;
    logic                   w_accept;
    logic                   r_pop;
    logic [ADDRESSSIZE-1:0] r_src;
    logic [ADDRESSSIZE-1:0] r_dst;
    logic [ADDRESSSIZE-1:0] r_rows;
    logic [c_CW-1:0]        r_rcnt;
    logic [c_CW-1:0]        r_wcnt;
    logic [c_CW-1:0]        w_wcnt_nxt;
    logic [c_CW-1:0]        w_rows_ext;
    logic [c_SW-1:0]        r_scnt;

    assign w_rows_ext = {1'b0, r_rows};
    assign w_wcnt_nxt = r_wcnt + {{ADDRESSSIZE{1'b0}}, res_write_enable};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (cfg_num_rows == '0)  w_next = DONE;
                    else if (reuse_weights)  w_next = SETTLE;
                    else                     w_next = WLOAD;
                end
            end
            WLOAD:   if (r_pop) w_next = WRELOAD;
            WRELOAD: w_next = SETTLE;
            SETTLE:  if (r_scnt == c_SW'(c_SETTLE_CYCLES - 1)) w_next = STREAM;
            STREAM:  if (r_rcnt + c_CW'(1) == w_rows_ext) w_next = DRAIN;
            // Look at the post-increment count so done follows the last
            // write by exactly one cycle.
            DRAIN:   if (w_wcnt_nxt == w_rows_ext) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, config and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pop   <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_rows  <= '0;
            r_rcnt  <= '0;
            r_wcnt  <= '0;
            r_scnt  <= '0;
        end else begin
            r_state <= w_next;
            // Registered pop: issued in the first WLOAD cycle whose
            // preceding cycle saw a non-empty FIFO; one pop per tile.
            r_pop   <= (w_next == WLOAD) && !fifo_empty;
            if (w_accept) begin
                r_src  <= cfg_src_base;
                r_dst  <= cfg_dst_base;
                r_rows <= cfg_num_rows;
                r_rcnt <= '0;
                r_wcnt <= '0;
                r_scnt <= '0;
            end else begin
                if (r_state == SETTLE) r_scnt <= r_scnt + c_SW'(1);
                if (r_state == STREAM) r_rcnt <= r_rcnt + c_CW'(1);
                if (res_write_enable)  r_wcnt <= w_wcnt_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fifo_read_enable = r_pop;
    assign we_rl            = (r_state == WRELOAD);
    assign ub_rd_en         = (r_state == STREAM);
    assign ub_address       = r_src + r_rcnt[ADDRESSSIZE-1:0];
    assign res_address      = r_dst + r_wcnt[ADDRESSSIZE-1:0];
    assign busy             = (r_state != IDLE) && (r_state != DONE);
    assign done             = (r_state == DONE);

    tpu_valid_delay #(
        .DEPTH (PIPE_LATENCY)
    ) u_valid_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (ub_rd_en),
        .dout (res_write_enable)
    );

`ifdef TPU_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [15:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else if (w_accept) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (busy && (r_perf_cycles != '1))
                r_perf_cycles <= r_perf_cycles + 32'd1;
            if ((r_state == WLOAD) && fifo_empty && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 16'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_tile_sequencer
// Purpose  : Self-checking bench for tpu_tile_sequencer. Each job is
//            described by an event timeline (pop, reload, read window, write
//            window, done) computed from the job parameters; every cycle the
//            packed DUT outputs are compared against that timeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_tile_sequencer;

    localparam int AW = 10;
    localparam int PL = 33;
    localparam int WS = 1;
    localparam int S  = (WS < 1) ? 1 : WS;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          reuse_weights;
    logic [AW-1:0] cfg_src_base;
    logic [AW-1:0] cfg_dst_base;
    logic [AW-1:0] cfg_num_rows;
    logic          fifo_empty;
    logic          fifo_read_enable;
    logic          we_rl;
    logic          ub_rd_en;
    logic [AW-1:0] ub_address;
    logic          res_write_enable;
    logic [AW-1:0] res_address;
    logic          busy;
    logic          done;
`ifdef TPU_SEQ_PERF_CNT_EN
    logic [31:0]   perf_cycles;
    logic [15:0]   perf_stall;
`endif

    always #5 clk = ~clk;

    tpu_tile_sequencer #(
        .ADDRESSSIZE  (AW),
        .MATRIX_SIZE  (16),
        .PIPE_LATENCY (PL),
        .WL_SETTLE    (WS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .reuse_weights    (reuse_weights),
        .cfg_src_base     (cfg_src_base),
        .cfg_dst_base     (cfg_dst_base),
        .cfg_num_rows     (cfg_num_rows),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .we_rl            (we_rl),
        .ub_rd_en         (ub_rd_en),
        .ub_address       (ub_address),
        .res_write_enable (res_write_enable),
        .res_address      (res_address),
        .busy             (busy),
        .done             (done)
`ifdef TPU_SEQ_PERF_CNT_EN
        ,
        .perf_cycles      (perf_cycles),
        .perf_stall       (perf_stall)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int job_id  = 0;

    // Timeline of the current job, in cycles relative to the start cycle.
    int j_rows, j_src, j_dst, j_pop, j_r0, j_done, j_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // {pop, reload, rd, rd_addr, wr, wr_addr, busy, done}; addresses masked
    // to 0 when their strobe is low.
    function automatic logic [31:0] observed();
        logic [AW-1:0] ra, wa;
        ra = ub_rd_en ? ub_address : '0;
        wa = res_write_enable ? res_address : '0;
        return {6'd0, fifo_read_enable, we_rl, ub_rd_en, ra, res_write_enable, wa, busy, done};
    endfunction

    function automatic logic [31:0] expected(input int rel);
        logic fre, wrl, rd, wr, bz, dn;
        logic [AW-1:0] ra, wa;
        fre = (rel == j_pop);
        wrl = (j_pop >= 0) && (rel == j_pop + 1);
        rd  = (j_rows > 0) && (rel >= j_r0) && (rel < j_r0 + j_rows);
        wr  = (j_rows > 0) && (rel >= j_r0 + PL) && (rel < j_r0 + PL + j_rows);
        ra  = rd ? AW'((j_src + rel - j_r0) % AMOD) : '0;
        wa  = wr ? AW'((j_dst + rel - j_r0 - PL) % AMOD) : '0;
        bz  = (j_rows > 0) && (rel >= 1) && (rel < j_done);
        dn  = (rel == j_done);
        return {6'd0, fre, wrl, rd, ra, wr, wa, bz, dn};
    endfunction

    // first_low: first cycle (relative to start) in which fifo_empty is 0.
    task automatic plan_job(input int rows, input int src, input int dst,
                            input bit reuse, input int first_low);
        j_rows  = rows;
        j_src   = src;
        j_dst   = dst;
        j_stall = 0;
        if (rows == 0) begin
            j_pop  = -1;
            j_r0   = -1;
            j_done = 1;
        end else if (reuse) begin
            j_pop  = -1;
            j_r0   = 1 + S;
            j_done = j_r0 + rows + PL;
        end else begin
            j_pop   = first_low + 1;
            j_r0    = j_pop + 2 + S;
            j_done  = j_r0 + rows + PL;
            j_stall = (first_low > 0) ? first_low - 1 : 0;
        end
    endtask

    task automatic scramble_cfg();
        reuse_weights = 1'($urandom);
        cfg_src_base  = AW'($urandom);
        cfg_dst_base  = AW'($urandom);
        cfg_num_rows  = AW'($urandom);
    endtask

    // Drives one job and checks every cycle through done+3.
    // abort_at > 0 applies a one-cycle reset after that relative cycle.
    task automatic run_job(input int rows, input int src, input int dst, input bit reuse,
                           input int first_low, input bit hammer, input int abort_at);
        job_id++;
        plan_job(rows, src, dst, reuse, first_low);
        @(negedge clk);
        start         = 1'b1;
        reuse_weights = reuse;
        cfg_src_base  = AW'(src);
        cfg_dst_base  = AW'(dst);
        cfg_num_rows  = AW'(rows);
        fifo_empty    = (first_low > 0);
        for (int rel = 1; rel <= j_done + 3; rel++) begin
            @(negedge clk);
            check($sformatf("job%0d_c%0d", job_id, rel), observed(), expected(rel));
            start      = hammer && (rel <= j_done);
            fifo_empty = (rel < first_low);
            scramble_cfg();
            if (abort_at > 0 && rel == abort_at) begin
                start = 1'b0;
                rst   = 1'b1;
                @(negedge clk);
                check($sformatf("job%0d_rst_outputs", job_id), observed(), 32'd0);
                rst = 1'b0;
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    check($sformatf("job%0d_post_rst%0d", job_id, k), observed(), 32'd0);
                end
                break;
            end
        end
        start      = 1'b0;
        fifo_empty = 1'b0;
`ifdef TPU_SEQ_PERF_CNT_EN
        if (abort_at == 0) begin
            check($sformatf("job%0d_perf_cycles", job_id), perf_cycles,
                  (rows > 0) ? 32'(j_done - 1) : 32'd0);
            check($sformatf("job%0d_perf_stall", job_id), {16'd0, perf_stall}, 32'(j_stall));
        end
`endif
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        reuse_weights = 1'b0;
        cfg_src_base  = '0;
        cfg_dst_base  = '0;
        cfg_num_rows  = '0;
        fifo_empty    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", observed(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", observed(), 32'd0);

        // Basic 4-row tile with weight load.
        run_job(4, 'h010, 'h200, 1'b0, 0, 1'b0, 0);
        // FIFO empty for the first 10 WLOAD cycles.
        run_job(3, 'h020, 'h100, 1'b0, 11, 1'b0, 0);
        // Weight reuse with source and destination wrap.
        run_job(2, 'h3FF, 'h3FE, 1'b1, 0, 1'b0, 0);
        // Zero-row jobs, with and without reuse.
        run_job(0, 'h055, 'h066, 1'b0, 0, 1'b0, 0);
        run_job(0, 'h077, 'h088, 1'b1, 3, 1'b0, 0);
        // start held high throughout a 3-row job.
        run_job(3, 'h123, 'h321, 1'b0, 2, 1'b1, 0);
        // Reset during STREAM of a 16-row tile.
        plan_job(16, 'h040, 'h080, 1'b0, 0);
        run_job(16, 'h040, 'h080, 1'b0, 0, 1'b0, j_r0 + 5);
        // Back-to-back job right after the abort.
        run_job(5, 'h3FC, 'h001, 1'b0, 0, 1'b0, 0);

        // Randomized jobs.
        for (int i = 0; i < 10; i++) begin
            run_job($urandom_range(1, 24), $urandom_range(0, AMOD - 1),
                    $urandom_range(0, AMOD - 1), 1'($urandom),
                    $urandom_range(0, 6), 1'($urandom_range(0, 3) == 0), 0);
        end

        // Maximum row count.
        run_job(AMOD - 1, $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
                1'b0, 1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
